// File: rtl/d8_fetch_ctrl.sv
// rtl/d8_fetch_ctrl.sv - dumb8 instruction fetch sequencer: PC, mem_inst read port, 2-entry decode buffer.
// Optional breakpoint stop on fetch address enabled by D8_FETCH_BRK_EN.
module d8_fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PC_STEP  = 8'h04
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        mem_en,
  output logic [7:0]  mem_adr,
  input  logic [31:0] mem_dout,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [7:0]  inst_pc,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        halt,
  output logic        busy
`ifdef D8_FETCH_BRK_EN
  ,
  input  logic        brk_en,
  input  logic [7:0]  brk_adr,
  output logic        brk_hit
`endif
);

  logic [7:0]       pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [7:0]       tag_q, tag_d;
  logic [1:0][31:0] word_q, word_d;
  logic [1:0][7:0]  bpc_q, bpc_d;
  logic [1:0]       count_q, count_d;
  logic [31:0]      last_word_q, last_word_d;
  logic [7:0]       last_pc_q, last_pc_d;

  logic             pop, push, brk_stop, brk_match;
  logic [2:0]       credit;
  logic [1:0]       wr_pos;

`ifdef D8_FETCH_BRK_EN
  logic             brk_hit_q, brk_hit_d;
  assign brk_match = brk_en & (pc_q == brk_adr);
  assign brk_stop  = brk_hit_q | brk_match;
  assign brk_hit   = brk_hit_q;
`else
  assign brk_match = 1'b0;
  assign brk_stop  = 1'b0;
`endif

  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? word_q[0] : last_word_q;
  assign inst_pc    = inst_valid ? bpc_q[0]  : last_pc_q;
  assign busy       = inflight_q | inst_valid;
  assign mem_adr    = pc_q;

  assign pop    = inst_valid & inst_ready & ~redirect;
  assign push   = inflight_q & ~redirect;
  // Slots already promised: buffered entries plus the one on the way, minus what leaves this edge.
  assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_en = sys_rst & ~halt & ~redirect & ~brk_stop & (credit < 3'd2);
  assign wr_pos = count_q - {1'b0, pop};

  always_comb begin
    pc_d        = pc_q;
    inflight_d  = 1'b0;
    tag_d       = tag_q;
    word_d      = word_q;
    bpc_d       = bpc_q;
    count_d     = count_q;
    last_word_d = last_word_q;
    last_pc_d   = last_pc_q;
`ifdef D8_FETCH_BRK_EN
    brk_hit_d   = brk_hit_q;
`endif
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = 2'd0;
`ifdef D8_FETCH_BRK_EN
      brk_hit_d = 1'b0;
`endif
    end else begin
      if (mem_en) begin
        pc_d       = pc_q + PC_STEP;
        inflight_d = 1'b1;
        tag_d      = pc_q;
      end
      if (pop) begin
        last_word_d = word_q[0];
        last_pc_d   = bpc_q[0];
        word_d[0]   = word_q[1];
        bpc_d[0]    = bpc_q[1];
      end
      if (push) begin
        word_d[wr_pos[0]] = mem_dout;
        bpc_d[wr_pos[0]]  = tag_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
`ifdef D8_FETCH_BRK_EN
      if (brk_match) brk_hit_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_q       <= 8'h00;
      word_q      <= '0;
      bpc_q       <= '0;
      count_q     <= 2'd0;
      last_word_q <= 32'h0;
      last_pc_q   <= 8'h00;
`ifdef D8_FETCH_BRK_EN
      brk_hit_q   <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      word_q      <= word_d;
      bpc_q       <= bpc_d;
      count_q     <= count_d;
      last_word_q <= last_word_d;
      last_pc_q   <= last_pc_d;
`ifdef D8_FETCH_BRK_EN
      brk_hit_q   <= brk_hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_d8_fetch_ctrl.sv
// tb/tb_d8_fetch_ctrl.sv - self-checking bench for d8_fetch_ctrl against an in-order fetch stream model.
module tb_d8_fetch_ctrl;
  localparam logic [7:0] RESET_PC = 8'h00;
  localparam logic [7:0] STEP     = 8'h04;
  localparam logic [7:0] OP_AFC   = 8'h0A;
  localparam logic [7:0] OP_VWR   = 8'h1E;

  logic        sys_clk = 1'b0;
  logic        sys_rst, mem_en, inst_valid, inst_ready, redirect, halt, busy;
  logic [7:0]  mem_adr, inst_pc, redirect_pc;
  logic [31:0] mem_dout, inst;
`ifdef D8_FETCH_BRK_EN
  logic        brk_en, brk_hit;
  logic [7:0]  brk_adr;
`endif

  always #5 sys_clk = ~sys_clk;

  d8_fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(STEP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mem_en(mem_en), .mem_adr(mem_adr),
    .mem_dout(mem_dout), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .busy(busy)
`ifdef D8_FETCH_BRK_EN
    , .brk_en(brk_en), .brk_adr(brk_adr), .brk_hit(brk_hit)
`endif
  );

  logic [7:0]  mem [256];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  exp_pc;
  logic [7:0]  last_pc;
  logic [31:0] last_word;
  int          pops, issues;

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  // Memory model: byte-addressed, little-endian word, registered one-cycle read.
  always @(posedge sys_clk) if (mem_en) mem_dout <= word_at(mem_adr);

  // One clock of stimulus plus the stream model: head must be the next expected address,
  // an empty buffer must hold the last delivered word, and halt/redirect block issue.
  task automatic drive_cycle(input logic rdy, input logic hlt, input logic rd, input logic [7:0] rpc);
    @(negedge sys_clk);
    inst_ready = rdy; halt = hlt; redirect = rd; redirect_pc = rpc;
    #1;
    if (mem_en) issues++;
    n_tests++;
    if ((hlt || rd) && mem_en) begin
      n_fail++; $display("FAIL issue_blocked: mem_en=%0b required 0 (halt=%0b redirect=%0b)", mem_en, hlt, rd);
    end
    n_tests++;
    if (inst_valid) begin
      if (inst_pc !== exp_pc || inst !== word_at(exp_pc)) begin
        n_fail++;
        $display("FAIL stream_head: inst_pc=%h inst=%h required pc=%h inst=%h", inst_pc, inst, exp_pc, word_at(exp_pc));
      end
      if (rdy && !rd) begin
        last_pc = exp_pc; last_word = word_at(exp_pc);
        exp_pc = exp_pc + STEP; pops++;
      end
    end else if (inst_pc !== last_pc || inst !== last_word) begin
      n_fail++;
      $display("FAIL hold_last: inst_pc=%h inst=%h required pc=%h inst=%h", inst_pc, inst, last_pc, last_word);
    end
    if (rd) exp_pc = rpc;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0; halt = 1'b1; redirect = 1'b0; inst_ready = 1'b0; redirect_pc = 8'h00;
`ifdef D8_FETCH_BRK_EN
    brk_en = 1'b0; brk_adr = 8'h00;
`endif
    @(negedge sys_clk);
    sys_rst = 1'b1;
    exp_pc = RESET_PC; last_pc = 8'h00; last_word = 32'h0; pops = 0; issues = 0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst = 1'b0; halt = 1'b0; redirect = 1'b0; inst_ready = 1'b1; redirect_pc = 8'h00;
`ifdef D8_FETCH_BRK_EN
    brk_en = 1'b0; brk_adr = 8'h00;
`endif
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: valid=%b busy=%b mem_en=%b required 0 0 0", inst_valid, busy, mem_en);
    end
    n_tests++;
    if (mem_adr !== RESET_PC || inst !== 32'h0 || inst_pc !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: adr=%h inst=%h pc=%h required %h 0 0", mem_adr, inst, inst_pc, RESET_PC);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (mem_en !== 1'b1 || mem_adr !== 8'h00 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_c0: en=%b adr=%h valid=%b required 1 00 0", mem_en, mem_adr, inst_valid);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (mem_adr !== 8'h04 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_c1: adr=%h valid=%b required 04 0", mem_adr, inst_valid);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst !== {OP_AFC, 24'h0}) begin
      n_fail++; $display("FAIL basic_first: valid=%b pc=%h inst=%h required 1 00 %h", inst_valid, inst_pc, inst, {OP_AFC, 24'h0});
    end
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1, 0, 0, 8'h00);
      n_tests++;
      if (inst_valid !== 1'b1 || inst_pc !== 8'(i * 4)) begin
        n_fail++; $display("FAIL basic_rate: valid=%b pc=%h required 1 %h", inst_valid, inst_pc, 8'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (6) drive_cycle(0, 0, 0, 8'h00);
    n_tests++;
    if (issues != 2 || mem_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_credit: issues=%0d en=%b busy=%b required 2 0 1", issues, mem_en, busy);
    end
    repeat (10) drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (pops != 10) begin
      n_fail++; $display("FAIL stall_release: pops=%0d required 10", pops);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (5) drive_cycle(1, 0, 0, 8'h00);
    drive_cycle(1, 0, 1, 8'h1C);
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b0 || mem_en !== 1'b1 || mem_adr !== 8'h1C) begin
      n_fail++; $display("FAIL redir_issue: valid=%b en=%b adr=%h required 0 1 1c", inst_valid, mem_en, mem_adr);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_stale: valid=%b required 0", inst_valid);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h1C || inst !== {OP_VWR, 8'hFF, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL redir_target: valid=%b pc=%h inst=%h required 1 1c %h", inst_valid, inst_pc, inst, {OP_VWR, 8'hFF, 8'h01, 8'h01});
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h20) begin
      n_fail++; $display("FAIL redir_next: valid=%b pc=%h required 1 20", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (3) drive_cycle(1, 0, 0, 8'h00);
    drive_cycle(1, 0, 1, 8'hFC);
    repeat (3) drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'hFC) begin
      n_fail++; $display("FAIL wrap_fc: valid=%b pc=%h required 1 fc", inst_valid, inst_pc);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin
      n_fail++; $display("FAIL wrap_00: valid=%b pc=%h required 1 00", inst_valid, inst_pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (4) drive_cycle(0, 0, 0, 8'h00);
    drive_cycle(1, 1, 0, 8'h00);
    n_tests++;
    if (mem_en !== 1'b0 || inst_pc !== 8'h00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_d0: en=%b pc=%h busy=%b required 0 00 1", mem_en, inst_pc, busy);
    end
    drive_cycle(1, 1, 0, 8'h00);
    n_tests++;
    if (inst_valid !== 1'b1 || inst_pc !== 8'h04) begin
      n_fail++; $display("FAIL halt_d1: valid=%b pc=%h required 1 04", inst_valid, inst_pc);
    end
    drive_cycle(1, 1, 0, 8'h00);
    n_tests++;
    if (busy !== 1'b0 || inst_valid !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_idle: busy=%b valid=%b en=%b required 0 0 0", busy, inst_valid, mem_en);
    end
    drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (mem_en !== 1'b1 || mem_adr !== 8'h08) begin
      n_fail++; $display("FAIL halt_resume: en=%b adr=%h required 1 08", mem_en, mem_adr);
    end
    repeat (4) drive_cycle(1, 0, 0, 8'h00);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) drive_cycle(1, 0, 0, 8'h00);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    #1;
    n_tests++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || mem_adr !== RESET_PC) begin
      n_fail++; $display("FAIL async_reset: valid=%b busy=%b en=%b adr=%h required 0 0 0 %h", inst_valid, busy, mem_en, mem_adr, RESET_PC);
    end
    do_reset();
    repeat (6) drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (pops != 4) begin
      n_fail++; $display("FAIL async_restart: pops=%0d required 4", pops);
    end
  endtask

  task automatic test_random();
    logic rdy, hlt, rd;
    logic [7:0] rpc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      hlt = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = 8'($urandom);
      drive_cycle(rdy, hlt, rd, rpc);
    end
    n_tests++;
    if (pops < 100) begin
      n_fail++; $display("FAIL random_progress: pops=%0d required >=100", pops);
    end
  endtask

`ifdef D8_FETCH_BRK_EN
  task automatic test_brk();
    do_reset();
    brk_en = 1'b1; brk_adr = 8'h08;
    repeat (8) drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (pops != 2 || brk_hit !== 1'b1 || mem_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL brk_stop: pops=%0d hit=%b en=%b busy=%b required 2 1 0 0", pops, brk_hit, mem_en, busy);
    end
    brk_en = 1'b0;
    drive_cycle(1, 0, 1, 8'h10);
    repeat (4) drive_cycle(1, 0, 0, 8'h00);
    n_tests++;
    if (brk_hit !== 1'b0 || pops != 4) begin
      n_fail++; $display("FAIL brk_resume: hit=%b pops=%0d required 0 4", brk_hit, pops);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = OP_AFC;
    mem[8'h1C] = 8'h01; mem[8'h1D] = 8'h01; mem[8'h1E] = 8'hFF; mem[8'h1F] = OP_VWR;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
`ifdef D8_FETCH_BRK_EN
    test_brk();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
